// File: rtl/uart_tx_buf_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_buf_ctrl
//
// Transmit byte buffer and sequencer that sits directly upstream of the UART
// transmitter. Host bytes go into a circular FIFO. The sequencer hands them to
// the transmitter one at a time: each byte is placed on txd_in together with a
// single-cycle tx_start pulse. The transmitter's level-type tx_ok (high for the
// stop-bit period) paces successive bytes, so frames run back-to-back without
// the host having to poll.
//
// Optional feature macro: UART_TX_EMPTY_IRQ_EN
//   When defined, the block adds tx_empty_irq (sticky, set when the last queued
//   byte finishes its stop bit) and irq_clr.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   tx_en        transmitter enable (same signal that drives the transmitter)
//   wr_en        host write strobe, one byte per cycle
//   wr_data      host byte
//   fifo_flush   synchronous FIFO clear
//   ovf_clr      clears the sticky overflow flag
//   full         FIFO holds 2^DEPTH_LOG2 bytes
//   empty        FIFO holds 0 bytes
//   count        current occupancy (registered)
//   overflow     sticky: a write was dropped
//   tx_busy      sequencer not in IDLE (registered)
//   tx_start     one-cycle start pulse to the transmitter
//   txd_in       byte to the transmitter, held until the sequencer is idle again
//   tx_ok        transmitter is in its stop-bit state (level)
//   irq_clr      clears tx_empty_irq            (UART_TX_EMPTY_IRQ_EN only)
//   tx_empty_irq last byte has completed        (UART_TX_EMPTY_IRQ_EN only)
//   dbg_state    sequencer state (0 IDLE, 1 WAIT_OK, 2 WAIT_CLR)
//
// Handshakes:
//   Host side is push-only: a byte is taken on every cycle wr_en=1 unless the
//   FIFO is full and no pop happens that cycle; such a byte is dropped and
//   overflow is set. Transmit side: tx_start is a one-cycle request with txd_in
//   valid; the sequencer treats tx_ok high-then-low as completion of that frame
//   and never issues a new tx_start while tx_ok is high.
// -----------------------------------------------------------------------------
module uart_tx_buf_ctrl #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_en,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  fifo_flush,
    input  logic                  ovf_clr,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  tx_busy,
    output logic                  tx_start,
    output logic [DATA_W-1:0]     txd_in,
    input  logic                  tx_ok,
`ifdef UART_TX_EMPTY_IRQ_EN
    input  logic                  irq_clr,
    output logic                  tx_empty_irq,
`endif
    output logic [1:0]            dbg_state
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_OK  = 2'd1,
        WAIT_CLR = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [DATA_W-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]    count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   tx_start_q, tx_start_d;
    logic                   tx_busy_q, tx_busy_d;
    logic [DATA_W-1:0]      txd_q, txd_d;
    logic                   pop, wr_acc, wr_drop;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign tx_busy   = tx_busy_q;
    assign tx_start  = tx_start_q;
    assign txd_in    = txd_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        txd_d      = txd_q;
        tx_start_d = 1'b0;

        // tx_ok is also required low so a transmitter still showing its stop
        // bit (e.g. after tx_en was toggled mid-frame) cannot swallow a start.
        pop     = (state_q == IDLE) && tx_en && !empty && !fifo_flush && !tx_ok;
        wr_acc  = wr_en && (!full || pop) && !fifo_flush;
        wr_drop = wr_en && full && !pop && !fifo_flush;

        // Sequencer: tx_en low overrides everything and drops the in-flight byte.
        if (!tx_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:     if (pop)    state_d = WAIT_OK;
                WAIT_OK:  if (tx_ok)  state_d = WAIT_CLR;
                WAIT_CLR: if (!tx_ok) state_d = IDLE;
                default:              state_d = IDLE;
            endcase
        end

        if (pop) begin
            txd_d      = mem_q[rd_ptr_q];
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            tx_start_d = 1'b1;
        end

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        if (fifo_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            case ({wr_acc, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end

        // A drop in the same cycle as ovf_clr keeps the flag set.
        if (wr_drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end

        tx_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_start_q <= 1'b0;
            tx_busy_q  <= 1'b0;
            txd_q      <= {DATA_W{1'b1}};
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_start_q <= tx_start_d;
            tx_busy_q  <= tx_busy_d;
            txd_q      <= txd_d;
        end
    end

    // Storage needs no reset: reset clears the pointers and count, which makes
    // any old contents unreachable.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

`ifdef UART_TX_EMPTY_IRQ_EN
    logic irq_q, irq_d, irq_set;

    // Set on the WAIT_CLR -> IDLE edge when nothing else is queued, i.e. the
    // last byte has just finished its stop bit. Set wins over clear.
    assign irq_set      = (state_q == WAIT_CLR) && tx_en && !tx_ok && empty;
    assign tx_empty_irq = irq_q;

    always_comb begin
        irq_d = irq_q;
        if (irq_set) begin
            irq_d = 1'b1;
        end else if (irq_clr) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_buf_ctrl.sv
`timescale 1ns/1ps
module tb_uart_tx_buf_ctrl;

    localparam int DL2 = 2;

    // ---------------- clock / reset / signals ----------------
    logic           clk        = 1'b0;
    logic           rst_n      = 1'b0;
    logic           tx_en      = 1'b0;
    logic           wr_en      = 1'b0;
    logic [7:0]     wr_data    = 8'h00;
    logic           fifo_flush = 1'b0;
    logic           ovf_clr    = 1'b0;
    logic           full, empty, overflow, tx_busy, tx_start;
    logic [DL2:0]   count;
    logic [7:0]     txd_in;
    logic [1:0]     dbg_state;
    logic           tx_ok;
    logic           tx_ok_man  = 1'b0;
    logic           tx_ok_m    = 1'b0;
    logic           model_on   = 1'b0;
`ifdef UART_TX_EMPTY_IRQ_EN
    logic           irq_clr    = 1'b0;
    logic           tx_empty_irq;
    logic           irq_early  = 1'b0;
`endif

    assign tx_ok = model_on ? tx_ok_m : tx_ok_man;

    always #5 clk = ~clk;

    uart_tx_buf_ctrl #(.DEPTH_LOG2(DL2), .DATA_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_en        (tx_en),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .fifo_flush   (fifo_flush),
        .ovf_clr      (ovf_clr),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
        .tx_busy      (tx_busy),
        .tx_start     (tx_start),
        .txd_in       (txd_in),
        .tx_ok        (tx_ok),
`ifdef UART_TX_EMPTY_IRQ_EN
        .irq_clr      (irq_clr),
        .tx_empty_irq (tx_empty_irq),
`endif
        .dbg_state    (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every tx_start pops the next expected byte.
    logic prev_start = 1'b0;
    always @(posedge clk) begin
        logic [7:0] e;
        #1;
        if (!rst_n) begin
            prev_start = 1'b0;
        end else begin
            if (tx_start) begin
                check("start_while_tx_ok", {31'd0, tx_ok}, 32'd0);
                check("start_pulse_width", {31'd0, prev_start}, 32'd0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL start_unexpected: got byte %02h, none expected at %0t", txd_in, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("start_byte", {24'd0, txd_in}, {24'd0, e});
                end
            end
            prev_start = tx_start;
`ifdef UART_TX_EMPTY_IRQ_EN
            if (tx_empty_irq && count != 0) irq_early = 1'b1;
`endif
        end
    end

    // Transmitter model: after a start, frame body, then 16 clk of tx_ok.
    always @(posedge clk) begin
        #1;
        if (model_on && tx_start) begin
            repeat (20) @(negedge clk);
            tx_ok_m = 1'b1;
            repeat (16) @(negedge clk);
            tx_ok_m = 1'b0;
        end
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic do_reset();
        rst_n = 1'b0;
        tx_en = 1'b0; wr_en = 1'b0; fifo_flush = 1'b0; ovf_clr = 1'b0;
        model_on = 1'b0; tx_ok_man = 1'b0;
`ifdef UART_TX_EMPTY_IRQ_EN
        irq_clr = 1'b0;
`endif
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((count != 0 || tx_busy || tx_ok || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, {31'd0, (n >= budget)}, 32'd0);
        check({name, "_queue"}, exp_q.size(), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        @(negedge clk);
        do_reset();

        // Reset state
        check("rst_count",    {29'd0, count}, 32'd0);
        check("rst_empty",    {31'd0, empty}, 32'd1);
        check("rst_full",     {31'd0, full}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_busy",     {31'd0, tx_busy}, 32'd0);
        check("rst_start",    {31'd0, tx_start}, 32'd0);
        check("rst_txd",      {24'd0, txd_in}, 32'h0000_00FF);
        check("rst_state",    {30'd0, dbg_state}, 32'd0);
`ifdef UART_TX_EMPTY_IRQ_EN
        check("rst_irq",      {31'd0, tx_empty_irq}, 32'd0);
`endif

        // Single byte A5, tx_ok driven by hand
        tx_en = 1'b1;
        exp_q.push_back(8'hA5);
        wr(8'hA5);
        check("t1_no_early_start", {31'd0, tx_start}, 32'd0);
        check("t1_count_1",        {29'd0, count}, 32'd1);
        @(negedge clk);
        check("t1_start",          {31'd0, tx_start}, 32'd1);
        check("t1_txd",            {24'd0, txd_in}, 32'h0000_00A5);
        check("t1_count_0",        {29'd0, count}, 32'd0);
        check("t1_busy",           {31'd0, tx_busy}, 32'd1);
        @(negedge clk);
        check("t1_start_low",      {31'd0, tx_start}, 32'd0);
        repeat (3) @(negedge clk);
        check("t1_busy_wait_ok",   {31'd0, tx_busy}, 32'd1);
        tx_ok_man = 1'b1;
        repeat (3) @(negedge clk);
        check("t1_state_wait_clr", {30'd0, dbg_state}, 32'd2);
        check("t1_busy_wait_clr",  {31'd0, tx_busy}, 32'd1);
        check("t1_txd_held",       {24'd0, txd_in}, 32'h0000_00A5);
        tx_ok_man = 1'b0;
        @(negedge clk);
        check("t1_idle_busy",      {31'd0, tx_busy}, 32'd0);
        check("t1_idle_state",     {30'd0, dbg_state}, 32'd0);
        check("t1_end_count",      {29'd0, count}, 32'd0);
`ifdef UART_TX_EMPTY_IRQ_EN
        check("t1_irq_set",        {31'd0, tx_empty_irq}, 32'd1);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        check("t1_irq_clr",        {31'd0, tx_empty_irq}, 32'd0);
`endif

        // Three bytes back-to-back with the transmitter model
        model_on = 1'b1;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h03);
        wr(8'h01);
        wr(8'h02);
        wr(8'h03);
        wait_drain("t2_drain", 500);
`ifdef UART_TX_EMPTY_IRQ_EN
        check("t2_irq_not_early", {31'd0, irq_early}, 32'd0);
        check("t2_irq_end",       {31'd0, tx_empty_irq}, 32'd1);
`endif

        // Overflow with tx_en low
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back(8'h10 + 8'(i));
            wr(8'h10 + 8'(i));
        end
        check("t3_count",    {29'd0, count}, 32'd4);
        check("t3_full",     {31'd0, full}, 32'd1);
        check("t3_empty",    {31'd0, empty}, 32'd0);
        check("t3_overflow", {31'd0, overflow}, 32'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("t3_ovf_clr",  {31'd0, overflow}, 32'd0);
        wr_en = 1'b1; wr_data = 8'h5A; ovf_clr = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; ovf_clr = 1'b0;
        check("t3_set_wins", {31'd0, overflow}, 32'd1);
        check("t3_count_drop", {29'd0, count}, 32'd4);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("t3_ovf_clr2", {31'd0, overflow}, 32'd0);
        model_on = 1'b1;
        tx_en = 1'b1;
        wait_drain("t3_drain", 800);

        // Full FIFO with same-cycle pop and write, then flush
        do_reset();
        model_on = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'h20 + 8'(i));
            wr(8'h20 + 8'(i));
        end
        check("t4_full_before", {31'd0, full}, 32'd1);
        tx_en = 1'b1;
        exp_q.push_back(8'h24);
        wr(8'h24);
        check("t4_count",    {29'd0, count}, 32'd4);
        check("t4_full",     {31'd0, full}, 32'd1);
        check("t4_overflow", {31'd0, overflow}, 32'd0);
        check("t4_start",    {31'd0, tx_start}, 32'd1);
        check("t4_txd",      {24'd0, txd_in}, 32'h0000_0020);
        fifo_flush = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
        @(negedge clk);
        fifo_flush = 1'b0; wr_en = 1'b0;
        exp_q.delete();
        check("t4_flush_count", {29'd0, count}, 32'd0);
        check("t4_flush_empty", {31'd0, empty}, 32'd1);
        check("t4_flush_full",  {31'd0, full}, 32'd0);
        check("t4_inflight",    {31'd0, tx_busy}, 32'd1);
        check("t4_txd_kept",    {24'd0, txd_in}, 32'h0000_0020);
        wait_drain("t4_drain", 200);

        // Drop tx_en in WAIT_OK
        do_reset();
        wr(8'h55);
        wr(8'h66);
        wr(8'h77);
        exp_q.push_back(8'h55);
        tx_en = 1'b1;
        @(negedge clk);
        check("t5_start",  {31'd0, tx_start}, 32'd1);
        check("t5_txd",    {24'd0, txd_in}, 32'h0000_0055);
        check("t5_count",  {29'd0, count}, 32'd2);
        @(negedge clk);
        check("t5_wait_ok", {30'd0, dbg_state}, 32'd1);
        tx_en = 1'b0;
        @(negedge clk);
        check("t5_idle",      {30'd0, dbg_state}, 32'd0);
        check("t5_busy",      {31'd0, tx_busy}, 32'd0);
        check("t5_start_low", {31'd0, tx_start}, 32'd0);
        repeat (3) @(negedge clk);
        check("t5_count_kept", {29'd0, count}, 32'd2);
        exp_q.push_back(8'h66);
        exp_q.push_back(8'h77);
        model_on = 1'b1;
        tx_en = 1'b1;
        wait_drain("t5_drain", 400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
